fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 13 +
 rtl/fetch_stage_npc.sv | 30 +++
 rtl/fetch_stage.sv | 63 ++++++
 tb/tb_fetch_stage.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared CPU constants for the fetch stage (reset PC, next-PC select encodings)
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BEQ = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_sel_e;

endpackage

// File: rtl/fetch_stage_npc.sv
// npc: combinational next-PC selection for sequential, beq, j/jal and jr flow
module npc
    import fetch_stage_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] id_pc_i,
    input  logic [1:0]  npc_sel_i,
    input  logic        cmp_out_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] imm26_i,
    input  logic [31:0] jr_target_i,
    output logic [31:0] npc_o
);

    logic [31:0] seq_pc;
    logic [31:0] br_pc;
    logic [31:0] j_pc;

    assign seq_pc = pc_i + 32'd4;
    assign br_pc  = id_pc_i + 32'd4 + {{14{imm16_i[15]}}, imm16_i, 2'b00};
    assign j_pc   = {id_pc_i[31:28], imm26_i, 2'b00};

    // Branch/jump targets are relative to the instruction in ID, the fall-through to the PC being fetched
    always_comb begin
        npc_o = (npc_sel_i == NPC_JR)                ? jr_target_i :
                (npc_sel_i == NPC_J)                 ? j_pc        :
                (npc_sel_i == NPC_BEQ && cmp_out_i)  ? br_pc       : seq_pc;
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register and IF/ID pipeline register with stall and one delay slot
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic        cmp_out,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] jr_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc8
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] npc_val;

    npc u_npc (
        .pc_i        (pc_q),
        .id_pc_i     (id_pc_q),
        .npc_sel_i   (npc_sel),
        .cmp_out_i   (cmp_out),
        .imm16_i     (imm16),
        .imm26_i     (imm26),
        .jr_target_i (jr_target),
        .npc_o       (npc_val)
    );

    // A stall freezes everything, so a held branch is re-evaluated with fresh cmp_out on release
    always_comb begin
        pc_d       = stall ? pc_q       : npc_val;
        id_instr_d = stall ? id_instr_q : imem_rdata;
        id_pc_d    = stall ? id_pc_q    : pc_q;
    end

    // Reset wins over stall and any pending redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            id_instr_q <= 32'h0000_0000;
            id_pc_q    <= 32'h0000_0000;
        end else begin
            pc_q       <= pc_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
        end
    end

    assign imem_addr = pc_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;
    assign id_pc8    = id_pc_q + 32'd8;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with directed scenarios and random traffic
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  npc_sel = 2'b00;
    logic        cmp_out = 1'b0;
    logic [15:0] imm16 = '0;
    logic [25:0] imm26 = '0;
    logic [31:0] jr_target = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc8;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    logic [31:0] m_pc, m_instr, m_idpc;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .npc_sel    (npc_sel),
        .cmp_out    (cmp_out),
        .imm16      (imm16),
        .imm26      (imm26),
        .jr_target  (jr_target),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_pc8     (id_pc8)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    assign imem_rdata = mem(imem_addr);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: every clock edge produces one architectural state to compare
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("imem_addr", imem_addr, e.addr);
            chk("id_instr", id_instr, e.instr);
            chk("id_pc", id_pc, e.pc);
            chk("id_pc8", id_pc8, e.pc8);
        end
    end

    task automatic step(input logic r, input logic s, input logic [1:0] sel, input logic c,
                        input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] jt);
        logic [31:0] nxt;
        exp_t x;
        @(negedge clk);
        reset = r; stall = s; npc_sel = sel; cmp_out = c;
        imm16 = i16; imm26 = i26; jr_target = jt;
        if (r) begin
            m_pc = 32'h0000_3000; m_instr = 32'h0; m_idpc = 32'h0;
        end else if (!s) begin
            if (sel == 2'd3)             nxt = jt;
            else if (sel == 2'd2)        nxt = (m_idpc & 32'hF000_0000) | (32'(i26) * 32'd4);
            else if (sel == 2'd1 && c)   nxt = 32'(int'(m_idpc) + 4 + 4 * int'($signed(i16)));
            else                         nxt = m_pc + 32'd4;
            m_instr = mem(m_pc);
            m_idpc  = m_pc;
            m_pc    = nxt;
        end
        x.addr = m_pc; x.instr = m_instr; x.pc = m_idpc; x.pc8 = m_idpc + 32'd8;
        sb.push_back(x);
    endtask

    task automatic seq();
        step(0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    endtask

    task automatic pin(input string name, input logic [31:0] a, input logic [31:0] p);
        @(posedge clk);
        #2;
        chk({name, " addr"}, imem_addr, a);
        chk({name, " id_pc"}, id_pc, p);
    endtask

    initial begin
        // Reset together with stall and a jump request
        step(1, 1, 2'd2, 1, 16'h0, 26'h3FF_FFFF, 32'hDEAD_BEEF);
        pin("rst", 32'h3000, 32'h0);
        chk("rst instr", id_instr, 32'h0);
        seq(); pin("run1", 32'h3004, 32'h3000);
        seq(); pin("run2", 32'h3008, 32'h3004);
        // Taken forward beq from 3004: delay slot 3008 enters IF/ID
        step(0, 0, 2'd1, 1, 16'h0003, 26'h0, 32'h0); pin("beq_t", 32'h3014, 32'h3008);
        seq(); pin("beq_after", 32'h3018, 32'h3014);
        step(0, 0, 2'd1, 0, 16'h0003, 26'h0, 32'h0); pin("beq_nt", 32'h301C, 32'h3018);
        // Backward beq at id_pc 3010
        step(1, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        seq();
        step(0, 0, 2'd3, 0, 16'h0, 26'h0, 32'h0000_300C);
        seq(); seq(); pin("pre_back", 32'h3014, 32'h3010);
        step(0, 0, 2'd1, 1, 16'hFFFF, 26'h0, 32'h0); pin("beq_back", 32'h3010, 32'h3014);
        // Stall three cycles with a pending beq, then release
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 2'd1, 1, 16'h0002, 26'h0, 32'h0);
            pin("stall", 32'h3010, 32'h3014);
        end
        step(0, 0, 2'd1, 1, 16'h0002, 26'h0, 32'h0); pin("release", 32'h3020, 32'h3010);
        seq(); pin("once", 32'h3024, 32'h3020);
        // j and jr
        step(1, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        seq();
        step(0, 0, 2'd2, 0, 16'h0, 26'h0000C40, 32'h0); pin("j", 32'h3100, 32'h3004);
        chk("pc8", id_pc8, 32'h300C);
        step(0, 0, 2'd3, 0, 16'h0, 26'h0, 32'h0000_3020); pin("jr", 32'h3020, 32'h3100);
        // Wrap-around and misaligned jr
        step(0, 0, 2'd3, 0, 16'h0, 26'h0, 32'hFFFF_FFFC);
        seq(); pin("wrap", 32'h0000_0000, 32'hFFFF_FFFC);
        chk("pc8 wrap", id_pc8, 32'h0000_0004);
        step(0, 0, 2'd3, 0, 16'h0, 26'h0, 32'h0000_4003); pin("mis", 32'h4003, 32'h0);
        // Reset mid-branch discards the redirect
        step(0, 1, 2'd1, 1, 16'h0100, 26'h0, 32'h0);
        step(1, 0, 2'd1, 1, 16'h0100, 26'h0, 32'h0); pin("rst_br", 32'h3000, 32'h0);
        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 16'($urandom), 26'($urandom),
                 ($urandom_range(0, 3) == 0) ? 32'($urandom) : {16'h0, 16'($urandom) & 16'hFFFC});
        end
        repeat (3) @(posedge clk);
        #3;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
